// File: rtl/binary_to_bcd_seq_if.sv
// Handshake bundle for the binary-to-BCD converter: a val/rdy input channel
// carrying the binary word and a val/rdy output channel carrying packed BCD.
interface binary_to_bcd_seq_if;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in_bin;
  logic        out_val;
  logic        out_rdy;
  logic [19:0] out_bcd;

  modport master (
    output in_val, in_bin, out_rdy,
    input  in_rdy, out_val, out_bcd
  );

  modport slave (
    input  in_val, in_bin, out_rdy,
    output in_rdy, out_val, out_bcd
  );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble: 16-bit unsigned binary to five packed BCD digits,
// one adjust+shift step per cycle, with val/rdy handshakes on both sides.
module binary_to_bcd_seq (
  input  logic                 clk,
  input  logic                 rst,
  binary_to_bcd_seq_if.slave   bus
);
  localparam int NUM_DIG = 5;
  localparam int DIG_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [15:0]                     bin_q, bin_d;
  logic [NUM_DIG*DIG_W-1:0]        bcd_q, bcd_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic [NUM_DIG*DIG_W-1:0]        res_q, res_d;
  logic                            in_rdy_q, in_rdy_d;
  logic                            out_val_q, out_val_d;

  logic [NUM_DIG-1:0][DIG_W-1:0]   dig_adj;
  logic [NUM_DIG*DIG_W+15:0]       sh_all;
  logic [NUM_DIG*DIG_W-1:0]        bcd_sh;
  logic [15:0]                     bin_sh;

  // Add-3 correction on every working digit before the shift.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    logic [DIG_W-1:0] d;
    assign d          = bcd_q[g*DIG_W +: DIG_W];
    assign dig_adj[g] = (d >= 4'd5) ? d + 4'd3 : d;
  end

  assign sh_all = {dig_adj, bin_q} << 1;
  assign bcd_sh = sh_all[35:16];
  assign bin_sh = sh_all[15:0];

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    in_rdy_d  = in_rdy_q;
    out_val_d = out_val_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_val) begin
          bin_d    = bus.in_bin;
          bcd_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
          in_rdy_d = 1'b0;
        end
      end
      S_CALC: begin
        bin_d = bin_sh;
        bcd_d = bcd_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          res_d     = bcd_sh;
          state_d   = S_DONE;
          out_val_d = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_rdy) begin
          state_d   = S_IDLE;
          in_rdy_d  = 1'b1;
          out_val_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        in_rdy_d  = 1'b1;
        out_val_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
    end
  end

  // Handshake outputs come straight from flops, so they depend on state only.
  assign bus.in_rdy  = in_rdy_q;
  assign bus.out_val = out_val_q;
  assign bus.out_bcd = res_q;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: a cycle-level behavioural model (decimal digit
// arithmetic plus a 16-cycle busy countdown) checked every cycle, plus directed literals.
module tb_binary_to_bcd_seq;
  logic clk;
  logic rst;
  binary_to_bcd_seq_if bif();

  binary_to_bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    p = 1;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Model: idle/busy/holding, expressed as a countdown of remaining cycles.
  logic        m_inrdy  = 1'b1;
  logic        m_outval = 1'b0;
  logic [19:0] m_res    = '0;
  logic [19:0] m_pend   = '0;
  int          m_cnt    = 0;
  int          m_fires  = 0;
  int          m_ofires = 0;
  int          cyc      = 0;
  int          m_last_fire = 0;
  int          m_prev_fire = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_inrdy  <= 1'b1;
      m_outval <= 1'b0;
      m_res    <= '0;
      m_cnt    <= 0;
    end else if (m_inrdy && bif.in_val) begin
      m_inrdy     <= 1'b0;
      m_cnt       <= 16;
      m_pend      <= to_bcd(int'(bif.in_bin));
      m_fires     <= m_fires + 1;
      m_prev_fire <= m_last_fire;
      m_last_fire <= cyc;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_outval <= 1'b1;
        m_res    <= m_pend;
      end
    end else if (m_outval && bif.out_rdy) begin
      m_outval <= 1'b0;
      m_inrdy  <= 1'b1;
      m_ofires <= m_ofires + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_rdy",  {31'd0, bif.in_rdy},  {31'd0, m_inrdy});
      chk("out_val", {31'd0, bif.out_val}, {31'd0, m_outval});
      chk("out_bcd", {12'd0, bif.out_bcd}, {12'd0, m_res});
      if (bif.out_val === 1'b1)
        for (int i = 0; i < 5; i++)
          chk("digit_range", {31'd0, bif.out_bcd[4*i +: 4] > 4'd9}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Fire v, expect first out_val in the 17th cycle after fire and result exp.
  task automatic conv(input logic [15:0] v, input logic [19:0] exp, input string nm);
    int n;
    n = 0;
    while (bif.in_rdy !== 1'b1 && n < 40) begin tick(); n++; end
    chk({nm, "_in_rdy"}, {31'd0, bif.in_rdy}, 32'd1);
    bif.in_val = 1'b1;
    bif.in_bin = v;
    tick();
    bif.in_val = 1'b0;
    n = 1;
    while (bif.out_val !== 1'b1 && n < 40) begin tick(); n++; end
    chk({nm, "_latency"}, n, 32'd17);
    chk({nm, "_bcd"}, {12'd0, bif.out_bcd}, {12'd0, exp});
    chk({nm, "_model"}, {12'd0, m_res}, {12'd0, exp});
    bif.out_rdy = 1'b1;
    tick();
  endtask

  task automatic wait_fires(input int target, input string nm);
    int n;
    n = 0;
    while (m_fires < target && n < 60) begin tick(); n++; end
    chk({nm, "_fire_timeout"}, {31'd0, m_fires >= target}, 32'd1);
  endtask

  initial begin
    int f0;
    int n;
    logic [15:0] rv;
    rst = 1'b1;
    bif.in_val  = 1'b0;
    bif.in_bin  = '0;
    bif.out_rdy = 1'b1;

    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_in_rdy",  {31'd0, bif.in_rdy},  32'd1);
    chk("rst_out_val", {31'd0, bif.out_val}, 32'd0);
    chk("rst_out_bcd", {12'd0, bif.out_bcd}, 32'h0);
    repeat (20) tick();
    chk("idle_in_rdy",  {31'd0, bif.in_rdy},  32'd1);
    chk("idle_out_bcd", {12'd0, bif.out_bcd}, 32'h0);

    // Boundary values
    conv(16'd0,     20'h00000, "b0");
    conv(16'd9,     20'h00009, "b9");
    conv(16'd10,    20'h00010, "b10");
    conv(16'd9999,  20'h09999, "b9999");
    conv(16'd65535, 20'h65535, "b65535");

    // Backpressure
    bif.out_rdy = 1'b0;
    bif.in_val = 1'b1;
    bif.in_bin = 16'd1234;
    tick();
    bif.in_val = 1'b0;
    n = 1;
    while (bif.out_val !== 1'b1 && n < 40) begin tick(); n++; end
    chk("bp_latency", n, 32'd17);
    f0 = m_fires;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_val", {31'd0, bif.out_val}, 32'd1);
      chk("bp_out_bcd", {12'd0, bif.out_bcd}, 32'h01234);
      chk("bp_in_rdy",  {31'd0, bif.in_rdy},  32'd0);
      bif.in_val = (i == 3);
      bif.in_bin = (i == 3) ? 16'd4321 : 16'd0;
      tick();
    end
    bif.in_val = 1'b0;
    chk("bp_ignored_fire", m_fires, f0);
    bif.out_rdy = 1'b1;
    tick();
    chk("bp_release_in_rdy", {31'd0, bif.in_rdy}, 32'd1);
    chk("bp_release_bcd", {12'd0, bif.out_bcd}, 32'h01234);

    // Back-to-back with in_val held high
    f0 = m_fires;
    bif.in_val = 1'b1;
    bif.in_bin = 16'd4095;
    wait_fires(f0 + 1, "b2b_a");
    bif.in_bin = 16'd40000;
    wait_fires(f0 + 2, "b2b_b");
    bif.in_val = 1'b0;
    chk("b2b_interval", m_last_fire - m_prev_fire, 32'd18);
    repeat (5) tick();
    chk("b2b_hold_bcd", {12'd0, bif.out_bcd}, 32'h04095);
    n = 0;
    while (bif.out_val !== 1'b1 && n < 40) begin tick(); n++; end
    chk("b2b_second_bcd", {12'd0, bif.out_bcd}, 32'h40000);
    tick();

    // Reset mid-conversion
    n = 0;
    while (bif.in_rdy !== 1'b1 && n < 40) begin tick(); n++; end
    bif.in_val = 1'b1;
    bif.in_bin = 16'd54321;
    tick();
    bif.in_val = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_val", {31'd0, bif.out_val}, 32'd0);
    chk("midrst_out_bcd", {12'd0, bif.out_bcd}, 32'h0);
    chk("midrst_in_rdy",  {31'd0, bif.in_rdy},  32'd1);
    conv(16'd100, 20'h00100, "post_rst");

    // Random values with random output stalls
    for (int k = 0; k < 200; k++) begin
      rv = 16'($urandom_range(0, 65535));
      f0 = m_ofires;
      n = 0;
      while (bif.in_rdy !== 1'b1 && n < 60) begin tick(); n++; end
      bif.in_val = 1'b1;
      bif.in_bin = rv;
      wait_fires(m_fires + 1, "rnd");
      bif.in_val = 1'b0;
      n = 0;
      while (m_ofires == f0 && n < 200) begin
        bif.out_rdy = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      chk("rnd_ofire_timeout", {31'd0, m_ofires != f0}, 32'd1);
    end
    bif.out_rdy = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Sequential double-dabble converter that turns a 16-bit unsigned binary value into five packed BCD digits, one shift/adjust step per cycle. It sits directly upstream of the per-digit seven-segment decoders on the FPGA display path. Each 4-bit slice of its output feeds one 4-bit-to-segment decoder instance. Input and output use val/rdy handshakes so a processor-side register or test harness can push values at any rate.

## Interface
- Parameters: none (widths fixed: 16-bit binary in, 5 BCD digits out)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_val  input  1  in_bin is valid
- in_rdy  output  1  block can accept a new value
- in_bin  input  16  unsigned binary value, sampled only on input fire (in_val & in_rdy)
- out_val  output  1  out_bcd holds a freshly completed result
- out_rdy  input  1  consumer accepts result
- out_bcd  output  20  packed BCD: [19:16]=ten-thousands, [15:12]=thousands, [11:8]=hundreds, [7:4]=tens, [3:0]=ones

## Operation
- Internal state: 2-bit FSM; 16-bit binary shift register; 20-bit BCD working register; 4-bit iteration counter; 20-bit output register (drives out_bcd).
- IDLE: in_rdy=1, out_val=0. On input fire: load binary register with in_bin, clear BCD working register and counter, go to CALC.
- CALC: in_rdy=0, out_val=0. Each cycle:
  - For each of the 5 working digits, if the digit is >=5, add 3.
  - Shift {bcd, bin} left by one as a 36-bit value. Bin MSB enters bcd LSB; bin LSB fills with 0.
  - Increment the counter.
  - On the cycle with counter==15 (the 16th iteration), write the post-shift BCD value into the output register and go to DONE.
- DONE: in_rdy=0, out_val=1. Hold out_bcd stable while out_rdy=0. On out_rdy=1, go to IDLE.
- out_bcd changes only when a conversion completes or on reset. Between conversions it keeps the last result, so the display stays steady.
- Width rule: the maximum input 65535 needs exactly 5 digits. Every digit of every result is 0–9. The ten-thousands digit never exceeds 6.
- in_val is ignored outside IDLE. in_bin is not re-sampled after fire.
- rst=1 in any state: next state IDLE; clear output register, working registers and counter. Any in-flight conversion is discarded.

## Timing
- Reset values: in_rdy=1 (IDLE), out_val=0, out_bcd=20'h00000.
- Latency: input fire at edge k puts the FSM in CALC for edges k+1 … k+16. At edge k+16 the FSM enters DONE, so out_val=1 in the cycle following edge k+16.
- Output fire at edge m puts the FSM in IDLE, so in_rdy=1 in the cycle after edge m.
- There is no same-cycle bypass from output fire to a new input fire. Minimum issue interval is 18 cycles.
- in_rdy depends only on state, with no combinational path from in_val, out_rdy or in_bin. out_val also depends only on state.
- rst has priority over all handshakes in the same cycle.

## Test plan
- Reset: hold rst 2 cycles, then release. Expect in_rdy=1, out_val=0, out_bcd=20'h00000. Keep in_val=0 for 20 cycles: no state change.
- Boundary values, each with out_rdy=1, checking out_val timing (first asserted in the 17th cycle after fire) and results:
  - 0 → 20'h00000
  - 9 → 20'h00009
  - 10 → 20'h00010
  - 9999 → 20'h09999
  - 65535 → 20'h65535
- Backpressure: convert 1234 with out_rdy=0 for 10 cycles after out_val rises.
  - out_val stays 1 and out_bcd stays 20'h01234 throughout.
  - in_rdy stays 0; an in_val pulse with 4321 is ignored.
  - Raise out_rdy: in_rdy=1 in the next cycle.
- Back-to-back: keep in_val=1 continuously with 4095 then 40000. Expect 20'h04095 then 20'h40000, fires 18 cycles apart. out_bcd holds 20'h04095 during the second CALC.
- Reset mid-operation: fire 54321 and assert rst at the 8th CALC cycle. Next cycle: out_val=0, out_bcd=20'h00000, in_rdy=1. A following conversion of 100 gives 20'h00100.
- Random: 200 random in_bin values with random out_rdy stalls, checked against a reference model (value/10^i mod 10 per digit).
